// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and constants for the divide-rate controller and its divider core.
package clkdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int MIN_RATE = 2;
  localparam int PERCNT_W = 16;

endpackage

// File: rtl/clkdiv_core.sv
// Programmable 50%-duty divider: counter 0..rate-1, posedge/negedge toggle flops, boundary detect.
module clkdiv_core #(
  parameter int COUNTER_WIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     run_en,
  input  logic [COUNTER_WIDTH-1:0] rate,
  output logic                     clk_o,
  output logic                     boundary
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] half_even, half_odd;
  logic                     rate_odd;
  logic                     div1_q, div2p_q, div2n_q;

  assign rate_odd  = rate[0];
  assign half_even = rate >> 1;
  assign half_odd  = (rate >> 1) + ONE;
  assign boundary  = run_en && (cnt_q == rate - ONE);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (!run_en || boundary) cnt_d = '0;
  end

  // Toggle flops are held (never cleared) when stopped: a full period toggles
  // each side once, so they already agree and clk_o rests low without a glitch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      div1_q  <= 1'b0;
      div2p_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (run_en && cnt_q == '0) div1_q <= ~div1_q;
      if (run_en && !rate_odd && cnt_q == half_even) div2p_q <= ~div2p_q;
    end
  end

  // Odd rates: falling edge gives the half-cycle needed for 50% duty.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div2n_q <= 1'b0;
    end else if (run_en && rate_odd && cnt_q == half_odd) begin
      div2n_q <= ~div2n_q;
    end
  end

  assign clk_o = div1_q ^ div2p_q ^ div2n_q;

endmodule

// File: rtl/clkdiv_rate_ctrl.sv
// Divide-rate controller: validates rate requests and applies them only at period boundaries.
// Optional feature macro CLKDIV_CTRL_PERCNT_EN adds the period_cnt_o boundary counter.
module clkdiv_rate_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int COUNTER_WIDTH = 7,
  parameter int DEFAULT_RATE  = 125
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     run_i,
  input  logic                     req_valid_i,
  input  logic [COUNTER_WIDTH-1:0] req_rate_i,
  output logic                     req_ready_o,
  output logic                     ack_o,
  output logic                     err_o,
  output logic [COUNTER_WIDTH-1:0] rate_o,
  output logic                     busy_o,
  output logic                     clk_o
`ifdef CLKDIV_CTRL_PERCNT_EN
  ,
  output logic [PERCNT_W-1:0]      period_cnt_o
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] MIN_RATE_W     = COUNTER_WIDTH'(MIN_RATE);
  localparam logic [COUNTER_WIDTH-1:0] DEFAULT_RATE_W = COUNTER_WIDTH'(DEFAULT_RATE);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] rate_q, rate_d;
  logic [COUNTER_WIDTH-1:0] pend_q, pend_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     busy_q;
  logic                     accept, req_ok, boundary;

  assign req_ready_o = (state_q != PEND);
  assign accept      = req_valid_i && req_ready_o;
  assign req_ok      = accept && (req_rate_i >= MIN_RATE_W);

  clkdiv_core #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_core (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .run_en  (state_q != STOP),
    .rate    (rate_q),
    .clk_o   (clk_o),
    .boundary(boundary)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= STOP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP:    if (run_i) state_d = RUN;
      RUN:     if (boundary && !run_i) state_d = STOP;
               else if (req_ok)        state_d = PEND;
      PEND:    if (boundary) state_d = run_i ? RUN : STOP;
      default: state_d = STOP;
    endcase
  end

  // A request accepted on the very boundary where the clock stops has no later
  // boundary to wait for, so it is applied immediately like a request in STOP.
  always_comb begin
    ack_d  = 1'b0;
    rate_d = rate_q;
    pend_d = pend_q;
    err_d  = accept && !req_ok;
    unique case (state_q)
      STOP: if (req_ok) begin
        ack_d  = 1'b1;
        rate_d = req_rate_i;
      end
      RUN: if (req_ok) begin
        if (boundary && !run_i) begin
          ack_d  = 1'b1;
          rate_d = req_rate_i;
        end else begin
          pend_d = req_rate_i;
        end
      end
      PEND: if (boundary) begin
        ack_d  = 1'b1;
        rate_d = pend_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rate_q <= DEFAULT_RATE_W;
      pend_q <= DEFAULT_RATE_W;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rate_q <= rate_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      busy_q <= (state_d == PEND);
    end
  end

  assign rate_o = rate_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

`ifdef CLKDIV_CTRL_PERCNT_EN
  logic [PERCNT_W-1:0] pcnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      pcnt_q <= '0;
    else if (ack_d)                    pcnt_q <= '0;
    else if (boundary && pcnt_q != '1) pcnt_q <= pcnt_q + PERCNT_W'(1);
  end

  assign period_cnt_o = pcnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_rate_ctrl.sv
// Self-checking bench for clkdiv_rate_ctrl: time-based reference model plus directed and random stimulus.
module tb_clkdiv_rate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       run_i;
  logic       req_valid_i;
  logic [6:0] req_rate_i;
  logic       req_ready_o, ack_o, err_o, busy_o, clk_o;
  logic [6:0] rate_o;
`ifdef CLKDIV_CTRL_PERCNT_EN
  logic [15:0] period_cnt_o;
`endif

  clkdiv_rate_ctrl dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .run_i       (run_i),
    .req_valid_i (req_valid_i),
    .req_rate_i  (req_rate_i),
    .req_ready_o (req_ready_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rate_o      (rate_o),
    .busy_o      (busy_o),
    .clk_o       (clk_o)
`ifdef CLKDIV_CTRL_PERCNT_EN
    ,
    .period_cnt_o(period_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: time elapsed in the current output period plus a pending flag.
  bit m_running, m_pending, m_ack, m_err;
  int m_rate, m_pend_rate, m_t, m_pc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_pending = 0; m_ack = 0; m_err = 0;
    m_rate = 125; m_pend_rate = 0; m_t = 0; m_pc = 0;
  endtask

  task automatic model_step();
    bit acc, good, n_ack, eop;
    int n;
    n     = int'(req_rate_i);
    acc   = req_valid_i && !m_pending;
    good  = acc && (n >= 2);
    n_ack = 0;
    m_err = acc && !good;
    if (!m_running) begin
      if (good) begin m_rate = n; n_ack = 1; end
      if (run_i) begin m_running = 1; m_t = 0; end
    end else begin
      eop = (m_t == m_rate - 1);
      if (eop) begin
        if (m_pending) begin
          m_rate = m_pend_rate; m_pending = 0; n_ack = 1;
        end else if (good && !run_i) begin
          m_rate = n; n_ack = 1;
        end else if (good) begin
          m_pending = 1; m_pend_rate = n;
        end
        m_t = 0;
        if (!run_i) m_running = 0;
      end else begin
        m_t++;
        if (good) begin m_pending = 1; m_pend_rate = n; end
      end
      if (n_ack) m_pc = 0;
      else if (eop && m_pc < 65535) m_pc++;
    end
    if (n_ack) m_pc = 0;
    m_ack = n_ack;
  endtask

  // Output high for the half-cycles [2, 2+N) of each 2N-half-cycle period.
  function automatic int exp_clk(input int off);
    int h;
    h = 2 * m_t + off;
    return (m_running && h >= 2 && h < 2 + m_rate) ? 1 : 0;
  endfunction

  always @(posedge clk_i) begin
    if (rst_n_i && chk_en) begin
      model_step();
      #1;
      if (rst_n_i && chk_en) begin
        chk("rate_o", int'(rate_o), m_rate);
        chk("ack_o", int'(ack_o), int'(m_ack));
        chk("err_o", int'(err_o), int'(m_err));
        chk("busy_o", int'(busy_o), int'(m_pending));
        chk("req_ready_o", int'(req_ready_o), int'(!m_pending));
        chk("clk_o_after_rise", int'(clk_o), exp_clk(0));
`ifdef CLKDIV_CTRL_PERCNT_EN
        chk("period_cnt_o", int'(period_cnt_o), m_pc);
`endif
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i && chk_en) begin
      #1;
      if (rst_n_i && chk_en) chk("clk_o_after_fall", int'(clk_o), exp_clk(1));
    end
  end

  task automatic send_req(input int n);
    int g;
    g = 0;
    @(negedge clk_i); #1;
    req_valid_i = 1'b1;
    req_rate_i  = 7'(n);
    while (!req_ready_o && g < 400) begin @(negedge clk_i); #1; g++; end
    if (g >= 400) chk("req_ready_timeout", 0, 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int g;
    g = 0;
    while (g < 400) begin
      @(posedge clk_i); #1;
      if (ack_o) break;
      g++;
    end
    if (g >= 400) chk({tag, "_ack_timeout"}, 0, 1);
  endtask

  task automatic measure(input int n, input string tag);
    int hi, lo, g;
    hi = 0; lo = 0; g = 0;
    while (clk_o !== 1'b0 && g < 1200) begin @(clk_i); #1; g++; end
    while (clk_o !== 1'b1 && g < 1200) begin @(clk_i); #1; g++; end
    while (clk_o === 1'b1 && g < 1200) begin hi++; @(clk_i); #1; g++; end
    while (clk_o === 1'b0 && g < 1200) begin lo++; @(clk_i); #1; g++; end
    chk({tag, "_high_halfcycles"}, hi, n);
    chk({tag, "_period_halfcycles"}, hi + lo, 2 * n);
  endtask

  initial begin
    int hi_cnt;
    rst_n_i = 1'b0; run_i = 1'b0; req_valid_i = 1'b0; req_rate_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("reset_rate_o", int'(rate_o), 125);
    chk("reset_clk_o", int'(clk_o), 0);
    chk("reset_ready", int'(req_ready_o), 1);
    chk("reset_ack", int'(ack_o), 0);
    chk("reset_err", int'(err_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk_en = 1'b1;

    // Free-running at the default rate.
    run_i = 1'b1;
    measure(125, "default_rate");

    // Invalid rate: error pulse, rate unchanged.
    send_req(1);
    chk("err_on_rate1", int'(err_o), 1);
    chk("rate_after_rate1", int'(rate_o), 125);
    repeat (130) @(posedge clk_i);

    // Mid-period change to 6.
    send_req(6);
    wait_ack("rate6");
    chk("rate_after_6", int'(rate_o), 6);
    measure(6, "rate6");

    // Back-to-back 9 then 11.
    send_req(9);
    @(negedge clk_i); #1;
    chk("ready_while_pending", int'(req_ready_o), 0);
    chk("busy_while_pending", int'(busy_o), 1);
    send_req(11);
    chk("rate_after_9", int'(rate_o), 9);
    wait_ack("rate11");
    chk("rate_after_11", int'(rate_o), 11);
    measure(11, "rate11");

    // Stop with 7 pending.
    send_req(7);
    run_i = 1'b0;
    wait_ack("stop7");
    chk("rate_after_stop7", int'(rate_o), 7);
    hi_cnt = 0;
    repeat (30) begin @(clk_i); #1; if (clk_o) hi_cnt++; end
    chk("clk_low_after_stop", hi_cnt, 0);
    chk("busy_after_stop", int'(busy_o), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i); #1;
      if ($urandom_range(0, 63) == 0) run_i = ~run_i;
      req_valid_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) req_rate_i = 7'($urandom_range(0, 127));
      else                           req_rate_i = 7'($urandom_range(0, 16));
    end
    @(negedge clk_i); #1;
    req_valid_i = 1'b0;
    run_i = 1'b1;
    repeat (5) @(posedge clk_i);

    // Reset asserted while a request is pending.
    send_req(120);
    wait_ack("rate120");
    send_req(5);
    repeat (10) @(posedge clk_i);
    #1;
    chk("busy_before_reset", int'(busy_o), 1);
    @(posedge clk_i); #3;
    chk_en  = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("async_reset_rate_o", int'(rate_o), 125);
    chk("async_reset_clk_o", int'(clk_o), 0);
    chk("async_reset_ready", int'(req_ready_o), 1);
    chk("async_reset_ack", int'(ack_o), 0);
    chk("async_reset_err", int'(err_o), 0);
    chk("async_reset_busy", int'(busy_o), 0);
`ifdef CLKDIV_CTRL_PERCNT_EN
    chk("async_reset_period_cnt", int'(period_cnt_o), 0);
`endif
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
    chk_en = 1'b1;
    repeat (300) @(posedge clk_i);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_rate_ctrl.md
# clkdiv_rate_ctrl

Run-time controller for the odd/even 50%-duty clock divider used to derive converter and codec clocks from the master clock. It accepts divide-rate change requests over a valid/ready handshake, validates them, and applies each one only at an output-period boundary so `clk_o` never glitches. It also starts and stops the divided clock cleanly on `run_i`. It contains the programmable divider core and sits between the control-register decoder and the clock consumers.

## Interface
- `COUNTER_WIDTH`, 7: width of the rate and counter fields.
- `DEFAULT_RATE`, 125: divide rate loaded at reset. Must be in the range 2 to 2^COUNTER_WIDTH-1.
- `clk_i` input, 1: master clock, the only clock.
- `rst_n_i` input, 1: reset, asynchronous, active-low.
- `run_i` input, 1: level. 1 = divided clock running, 0 = stop at the next period boundary.
- `req_valid_i` input, 1: rate-change request valid.
- `req_rate_i` input, COUNTER_WIDTH: requested divide rate N.
- `req_ready_o` output, 1: controller can accept a request.
- `ack_o` output, 1: one-cycle pulse when an accepted rate takes effect.
- `err_o` output, 1: one-cycle pulse when an accepted request is rejected (N<2).
- `rate_o` output, COUNTER_WIDTH: divide rate currently in effect.
- `busy_o` output, 1: a request is pending.
- `clk_o` output, 1: divided clock, 50% duty.

## Operation
- States:
  - STOP: counter held at 0, `clk_o`=0.
  - RUN: no request pending.
  - PEND: a valid request is waiting for a period boundary.
- Boundary: the posedge at which the core counter equals `rate_o`-1 while in RUN or PEND. The counter wraps to 0 on that edge.
- Handshake: a request is accepted on a posedge with `req_valid_i`=1 and `req_ready_o`=1. `req_ready_o` = (state != PEND).
- Request with N<2: accepted, `err_o` pulses on the next cycle, state and rate are unchanged, and no `ack_o` is issued.
- Valid request in RUN: latched, state goes to PEND. At the next boundary, `rate_o` takes N, the counter wraps to 0, `ack_o` pulses, and state returns to RUN.
- Valid request in STOP: `rate_o` takes N on the next posedge, `ack_o` pulses on that same posedge, and state stays STOP.
- `run_i` falling in RUN or PEND: the current period completes. At the boundary, any pending rate is applied with `ack_o`, then state goes to STOP. `clk_o` ends low.
- `run_i`=1 in STOP: state goes to RUN on the next posedge and the counter starts from 0.
- Core:
  - Counter runs 0..N-1.
  - `div1` toggles on the posedge that leaves count 0.
  - N even: `div2` toggles on the posedge that leaves count N/2.
  - N odd: `div2` toggles on the negedge following count (N-1)/2+1.
  - `clk_o` = `div1` ^ `div2`.
- Duty: `clk_o` is high for N/2 input periods, with half-cycle resolution for odd N. Period is N input periods.
- Arithmetic: the counter and its comparisons are unsigned COUNTER_WIDTH bits. No rate can exceed 2^W-1, so no overflow is possible.

## Timing
- Reset values: state STOP, `rate_o`=DEFAULT_RATE, `clk_o`=0, `req_ready_o`=1, `ack_o`=0, `err_o`=0, `busy_o`=0. Reset clears `div1`, `div2` and the counter.
- Latency from accept to `ack_o`:
  - RUN: 1 to N_old cycles.
  - STOP: 1 cycle.
- An accept on the boundary cycle itself is applied at the following boundary, not at the current one.
- `busy_o` is registered and equals (state == PEND).
- First `clk_o` rising edge after STOP→RUN: 1 posedge after the transition.
- Reset asserted mid-period: all outputs go to reset values immediately. Any pending request is discarded without `ack_o`.

## Configuration
- `CLKDIV_CTRL_PERCNT_EN` defined: adds output `period_cnt_o` (16 bits).
  - Increments at each boundary while in RUN or PEND.
  - Clears to 0 on reset and on every `ack_o`.
  - Saturates at 0xFFFF.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package `clkdiv_ctrl_pkg`: state enum {STOP, RUN, PEND}, `MIN_RATE`=2, `PERCNT_W`=16.
- Sub-module `clkdiv_core`:
  - Contains the counter, `div1`/`div2` and the boundary detect.
  - Inputs: `rate`, `run_en`.
  - Outputs: `clk_o`, `boundary`.
- The controller FSM and the request latch stay in the top level.

## Test plan
- Reset, then `run_i`=1, with no requests → `clk_o` period 125 input cycles, high 62.5 cycles, `rate_o`=125.
- Request N=6 mid-period of N=125 → `ack_o` at the boundary, next periods are 6 cycles with 3 high, and no runt pulse on `clk_o`.
- Request N=1 → `err_o` pulse, `rate_o` stays 125, no `ack_o`.
- Two back-to-back requests (N=9, then N=11) → `req_ready_o`=0 while pending. N=9 is applied at the first boundary, N=11 at the boundary after.
- `run_i` dropped with N=7 pending → the current period completes, then `ack_o` pulses, state goes to STOP, `clk_o` holds 0, and `rate_o`=7.
- Assert `rst_n_i` during PEND → all outputs at reset values asynchronously and `rate_o`=125. With `CLKDIV_CTRL_PERCNT_EN` defined, `period_cnt_o`=0.
